// File: rtl/ctrl_pipe_unit.sv
// Decode stage control for the 5-stage core: opcode decode into the D/X register,
// load-use and mult/div hazard detection, and bubble insertion on stalls and redirects.
module ctrl_pipe_unit #(
    parameter int OP_W       = 5,
    parameter int REG_W      = 5,
    parameter int CTRL_W     = 16,
    parameter int MD_CYCLES  = 32,
    parameter int JAL_REG    = 31,
    parameter int STATUS_REG = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fd_valid,
    input  logic [OP_W-1:0]   fd_op,
    input  logic [4:0]        fd_aluop,
    input  logic [REG_W-1:0]  fd_rs,
    input  logic [REG_W-1:0]  fd_rt,
    input  logic [REG_W-1:0]  fd_rd,
    input  logic              branch_taken,
    output logic [CTRL_W-1:0] dx_ctrl,
    output logic              dx_valid,
    output logic [REG_W-1:0]  dx_rd,
    output logic              stall,
    output logic              md_busy
);

    localparam int CNT_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(5'b00000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(5'b00001);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5'b00010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(5'b00011);
    localparam logic [OP_W-1:0] OP_JR    = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(5'b00101);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(5'b00110);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(5'b00111);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(5'b01000);
    localparam logic [OP_W-1:0] OP_SETX  = OP_W'(5'b10101);
    localparam logic [OP_W-1:0] OP_BEX   = OP_W'(5'b10110);

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam int B_RWE     = 0;
    localparam int B_RDST_I  = 1;
    localparam int B_ALU_IMM = 2;
    localparam int B_DMWE    = 3;
    localparam int B_MEM2REG = 4;
    localparam int B_JUMP    = 5;
    localparam int B_BNE     = 6;
    localparam int B_BLT     = 7;
    localparam int B_JAL     = 8;
    localparam int B_JR      = 9;
    localparam int B_BEX     = 10;
    localparam int B_SETX    = 11;
    localparam int B_MULT    = 12;
    localparam int B_DIV     = 13;
    localparam int B_ADDI    = 14;
    localparam int B_ILLEGAL = 15;

    function automatic logic [15:0] decode_ctrl(input logic [OP_W-1:0] op,
                                                input logic [4:0]      aluop);
        logic [15:0] c;
        c = 16'h0000;
        case (op)
            OP_RTYPE: begin
                c[B_RWE] = 1'b1;
                if (aluop == ALU_MULT) begin
                    c[B_MULT] = 1'b1;
                end else if (aluop == ALU_DIV) begin
                    c[B_DIV] = 1'b1;
                end else begin
                    c[B_MULT] = 1'b0;
                end
            end
            OP_ADDI: begin
                c[B_RWE]     = 1'b1;
                c[B_RDST_I]  = 1'b1;
                c[B_ALU_IMM] = 1'b1;
                c[B_ADDI]    = 1'b1;
            end
            OP_LW: begin
                c[B_RWE]     = 1'b1;
                c[B_RDST_I]  = 1'b1;
                c[B_ALU_IMM] = 1'b1;
                c[B_MEM2REG] = 1'b1;
            end
            OP_SW: begin
                c[B_ALU_IMM] = 1'b1;
                c[B_DMWE]    = 1'b1;
            end
            OP_J:    c[B_JUMP] = 1'b1;
            OP_BNE:  c[B_BNE]  = 1'b1;
            OP_BLT:  c[B_BLT]  = 1'b1;
            OP_JAL: begin
                c[B_JUMP] = 1'b1;
                c[B_JAL]  = 1'b1;
                c[B_RWE]  = 1'b1;
            end
            OP_JR:   c[B_JR]  = 1'b1;
            OP_BEX:  c[B_BEX] = 1'b1;
            OP_SETX: begin
                c[B_SETX] = 1'b1;
                c[B_RWE]  = 1'b1;
            end
            default: c[B_ILLEGAL] = 1'b1;
        endcase
        return c;
    endfunction

    // Link and status writes use fixed registers; non-writing instructions carry tag 0.
    function automatic logic [REG_W-1:0] decode_rd(input logic [15:0]      c,
                                                   input logic [REG_W-1:0] rd);
        logic [REG_W-1:0] r;
        if (!c[B_RWE]) begin
            r = {REG_W{1'b0}};
        end else if (c[B_JAL]) begin
            r = REG_W'(JAL_REG);
        end else if (c[B_SETX]) begin
            r = REG_W'(STATUS_REG);
        end else begin
            r = rd;
        end
        return r;
    endfunction

    logic [CTRL_W-1:0] dx_ctrl_q, dx_ctrl_d;
    logic              dx_valid_q, dx_valid_d;
    logic [REG_W-1:0]  dx_rd_q, dx_rd_d;
    logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;
    logic              md_busy_q, md_busy_d;

    logic [15:0]       dec_ctrl_s;
    logic [REG_W-1:0]  dec_rd_s;
    logic              load_use_s;
    logic              md_hz_s;
    logic              stall_s;
    logic              issue_s;
    logic              issue_md_s;

    // Decode, hazard detection and next-state selection for the D/X register.
    always_comb begin
        dec_ctrl_s = decode_ctrl(fd_op, fd_aluop);
        dec_rd_s   = decode_rd(dec_ctrl_s, fd_rd);

        load_use_s = dx_valid_q & dx_ctrl_q[B_MEM2REG] & (dx_rd_q != {REG_W{1'b0}}) &
                     fd_valid & ((dx_rd_q == fd_rs) | (dx_rd_q == fd_rt));
        md_hz_s    = md_busy_q & fd_valid;
        stall_s    = (load_use_s | md_hz_s) & ~branch_taken;

        issue_s    = ~branch_taken & ~stall_s & fd_valid;
        issue_md_s = issue_s & (dec_ctrl_s[B_MULT] | dec_ctrl_s[B_DIV]);

        if (issue_s) begin
            dx_valid_d = 1'b1;
            dx_ctrl_d  = CTRL_W'(dec_ctrl_s);
            dx_rd_d    = dec_rd_s;
        end else begin
            dx_valid_d = 1'b0;
            dx_ctrl_d  = {CTRL_W{1'b0}};
            dx_rd_d    = {REG_W{1'b0}};
        end

        // A redirect never cancels an in-flight mult/div, so the counter ignores branch_taken.
        if (issue_md_s) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != {CNT_W{1'b0}}) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end else begin
            md_cnt_d = {CNT_W{1'b0}};
        end
        md_busy_d = (md_cnt_d != {CNT_W{1'b0}});
    end

    // D/X pipeline register and mult/div tracking state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dx_ctrl_q  <= {CTRL_W{1'b0}};
            dx_valid_q <= 1'b0;
            dx_rd_q    <= {REG_W{1'b0}};
            md_cnt_q   <= {CNT_W{1'b0}};
            md_busy_q  <= 1'b0;
        end else begin
            dx_ctrl_q  <= dx_ctrl_d;
            dx_valid_q <= dx_valid_d;
            dx_rd_q    <= dx_rd_d;
            md_cnt_q   <= md_cnt_d;
            md_busy_q  <= md_busy_d;
        end
    end

    assign dx_ctrl  = dx_ctrl_q;
    assign dx_valid = dx_valid_q;
    assign dx_rd    = dx_rd_q;
    assign stall    = stall_s;
    assign md_busy  = md_busy_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: a driver computes expected D/X state and stall from
// an instruction-level model, and a monitor compares them mid-cycle.
module tb_ctrl_pipe_unit;

    localparam int MD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fd_valid = 1'b0;
    logic [4:0]  fd_op = 5'd0;
    logic [4:0]  fd_aluop = 5'd0;
    logic [4:0]  fd_rs = 5'd0;
    logic [4:0]  fd_rt = 5'd0;
    logic [4:0]  fd_rd = 5'd0;
    logic        branch_taken = 1'b0;
    logic [15:0] dx_ctrl;
    logic        dx_valid;
    logic [4:0]  dx_rd;
    logic        stall;
    logic        md_busy;

    ctrl_pipe_unit #(.MD_CYCLES(MD)) dut (
        .clock(clock), .reset(reset), .fd_valid(fd_valid), .fd_op(fd_op),
        .fd_aluop(fd_aluop), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rd(fd_rd),
        .branch_taken(branch_taken), .dx_ctrl(dx_ctrl), .dx_valid(dx_valid),
        .dx_rd(dx_rd), .stall(stall), .md_busy(md_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [15:0] ctrl;
        logic [4:0]  rd;
        logic        busy;
        logic        stall;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Instruction-level model: what is in D/X, and which cycle the last mult/div issued.
    logic        mv = 1'b0;
    logic [15:0] mctrl = 16'h0000;
    logic [4:0]  mrd = 5'd0;
    int          last_issue = -100;
    int          k = 0;

    function automatic logic [15:0] ref_ctrl(input logic [4:0] op, input logic [4:0] aluop);
        case (op)
            5'd0:    return (aluop == 5'd6) ? 16'h1001 : (aluop == 5'd7) ? 16'h2001 : 16'h0001;
            5'd1:    return 16'h0020;
            5'd2:    return 16'h0040;
            5'd3:    return 16'h0121;
            5'd4:    return 16'h0200;
            5'd5:    return 16'h4007;
            5'd6:    return 16'h0080;
            5'd7:    return 16'h000C;
            5'd8:    return 16'h0017;
            5'd21:   return 16'h0801;
            5'd22:   return 16'h0400;
            default: return 16'h8000;
        endcase
    endfunction

    function automatic logic [4:0] ref_rd(input logic [4:0] op, input logic [4:0] rd);
        if (op == 5'd3) return 5'd31;
        if (op == 5'd21) return 5'd30;
        if (op == 5'd0 || op == 5'd5 || op == 5'd8) return rd;
        return 5'd0;
    endfunction

    // busy in the MD-1 cycles starting with the one right after the issuing edge
    function automatic logic m_busy(input int kk);
        return (last_issue >= 0) && (kk >= last_issue) && (kk - last_issue <= MD - 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic fv, input logic [4:0] op, input logic [4:0] aluop,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic br, input logic rst_v, output logic st);
        exp_t e;
        logic lu;
        @(posedge clock);
        #2;
        reset = rst_v; fd_valid = fv; fd_op = op; fd_aluop = aluop;
        fd_rs = rs; fd_rt = rt; fd_rd = rd; branch_taken = br;
        if (!rst_v) begin
            mv = 1'b0; mctrl = 16'h0000; mrd = 5'd0; last_issue = -100;
        end
        lu = mv && mctrl[4] && (mrd != 5'd0) && fv && (mrd == rs || mrd == rt);
        st = (lu || (m_busy(k) && fv)) && !br;
        e.v = mv; e.ctrl = mctrl; e.rd = mrd; e.busy = m_busy(k); e.stall = st;
        sb.push_back(e);
        if (rst_v && !br && !st && fv) begin
            mv = 1'b1; mctrl = ref_ctrl(op, aluop); mrd = ref_rd(op, rd);
            if (mctrl[12] || mctrl[13]) last_issue = k + 1;
        end else begin
            mv = 1'b0; mctrl = 16'h0000; mrd = 5'd0;
        end
        k++;
    endtask

    task automatic idle(input int n);
        logic st;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, st);
    endtask

    // Present an instruction and hold it in F/D until it is accepted.
    task automatic send(input logic [4:0] op, input logic [4:0] aluop, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
        logic st;
        st = 1'b1;
        for (int i = 0; i < 20 && st; i++) step(1'b1, op, aluop, rs, rt, rd, 1'b0, 1'b1, st);
        if (st) begin
            total++; bad++;
            $display("FAIL send_bound: instruction op=%0h still stalled after 20 cycles", op);
        end
    endtask

    // Monitor: compare every presented D/X state and stall against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("dx_valid", {31'd0, dx_valid}, {31'd0, e.v});
                chk("dx_ctrl", {16'd0, dx_ctrl}, {16'd0, e.ctrl});
                chk("dx_rd", {27'd0, dx_rd}, {27'd0, e.rd});
                chk("md_busy", {31'd0, md_busy}, {31'd0, e.busy});
                chk("stall", {31'd0, stall}, {31'd0, e.stall});
            end
        end
    end

    // Driver: directed scenarios followed by a randomized run.
    initial begin
        logic st;
        logic [4:0] op, al, rs, rt, rd;
        logic fv, br, rv;
        logic [4:0] ops [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd21, 5'd22};

        for (int i = 0; i < 2; i++)
            step(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 1'($urandom), 1'b0, st);
        idle(3);

        send(5'd5, 5'd0, 5'd1, 5'd2, 5'd5);
        send(5'd8, 5'd0, 5'd1, 5'd2, 5'd7);
        send(5'd7, 5'd0, 5'd1, 5'd2, 5'd3);
        send(5'd3, 5'd0, 5'd1, 5'd2, 5'd9);
        idle(2);

        send(5'd8, 5'd0, 5'd1, 5'd2, 5'd7);
        send(5'd0, 5'd0, 5'd7, 5'd3, 5'd4);
        idle(1);
        send(5'd8, 5'd0, 5'd1, 5'd2, 5'd0);
        send(5'd0, 5'd0, 5'd0, 5'd0, 5'd4);
        idle(1);
        send(5'd8, 5'd0, 5'd1, 5'd2, 5'd7);
        step(1'b1, 5'd0, 5'd0, 5'd7, 5'd3, 5'd4, 1'b1, 1'b1, st);
        idle(2);

        send(5'd0, 5'd6, 5'd1, 5'd2, 5'd3);
        send(5'd0, 5'd0, 5'd3, 5'd4, 5'd5);
        idle(1);
        send(5'd0, 5'd7, 5'd1, 5'd2, 5'd3);
        step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, st);
        idle(4);

        send(5'd31, 5'd0, 5'd7, 5'd7, 5'd7);
        send(5'd0, 5'd0, 5'd0, 5'd0, 5'd2);
        send(5'd31, 5'd0, 5'd7, 5'd7, 5'd7);
        send(5'd0, 5'd0, 5'd7, 5'd7, 5'd2);
        idle(1);

        send(5'd0, 5'd6, 5'd1, 5'd2, 5'd3);
        step(1'b1, 5'd0, 5'd0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1, st);
        step(1'b1, 5'd0, 5'd0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, st);
        step(1'b1, 5'd0, 5'd0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, st);
        step(1'b1, 5'd0, 5'd0, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1, st);
        idle(2);

        st = 1'b0;
        op = 5'd0; al = 5'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; fv = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                fv = ($urandom_range(0, 4) != 0);
                case ($urandom_range(0, 3))
                    0:       op = 5'd8;
                    1:       op = 5'($urandom);
                    default: op = ops[$urandom_range(0, 9)];
                endcase
                case ($urandom_range(0, 5))
                    0:       al = 5'd6;
                    1:       al = 5'd7;
                    default: al = 5'($urandom);
                endcase
                rs = 5'($urandom_range(0, 3));
                rt = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
            end
            br = ($urandom_range(0, 9) == 0);
            rv = ($urandom_range(0, 59) != 0);
            step(fv, op, al, rs, rt, rd, br, rv, st);
        end
        idle(2);

        repeat (2) @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d scoreboard entries never checked", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
- Pipelined successor to the single-cycle opcode decoder.
- Decodes the F/D-stage opcode into a named control word and registers it into the D/X pipeline register with a destination-register tag.
- Detects load-use hazards, inserts bubbles on stalls and taken branches, and tracks a multi-cycle mult/div unit with a busy counter.
- Sits between the F/D latch and the execute stage of the 5-stage core.

Parameters:
- OP_W, 5, opcode width.
- REG_W, 5, register-index width.
- CTRL_W, 16, control-word width; must be >= 16, and bits above 15 are driven 0.
- MD_CYCLES, 32, mult/div latency in cycles; must be >= 2.
- JAL_REG, 31, link register written by jal.
- STATUS_REG, 30, register written by setx.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fd_valid  in  1  F/D holds a real instruction.
- fd_op  in  OP_W  opcode.
- fd_aluop  in  5  ALU op for R-type; 00110 = mult, 00111 = div.
- fd_rs  in  REG_W  source register A.
- fd_rt  in  REG_W  source register B.
- fd_rd  in  REG_W  instruction rd field.
- branch_taken  in  1  X stage resolved a redirect (branch, jump or bex) this cycle.
- dx_ctrl  out  CTRL_W  registered control word.
- dx_valid  out  1  registered; D/X holds a real instruction.
- dx_rd  out  REG_W  registered destination register.
- stall  out  1  combinational; upstream holds PC and F/D this cycle.
- md_busy  out  1  registered; mult/div in progress.

Behaviour:
- Opcode map:
  - 00000 R-type
  - 00001 j
  - 00010 bne
  - 00011 jal
  - 00100 jr
  - 00101 addi
  - 00110 blt
  - 00111 sw
  - 01000 lw
  - 10101 setx
  - 10110 bex
  - any other opcode = illegal
- Control bits:
  - [0] rwe
  - [1] rdst_i
  - [2] alu_imm
  - [3] dmwe
  - [4] mem2reg
  - [5] jump
  - [6] bne
  - [7] blt
  - [8] jal
  - [9] jr
  - [10] bex
  - [11] setx
  - [12] mult
  - [13] div
  - [14] addi
  - [15] illegal
- Decode per opcode:
  - R-type: rwe. Also mult if fd_aluop == 00110, div if fd_aluop == 00111.
  - addi: rwe, rdst_i, alu_imm, addi.
  - lw: rwe, rdst_i, alu_imm, mem2reg.
  - sw: alu_imm, dmwe.
  - j: jump.
  - bne: bne.
  - blt: blt.
  - jal: jump, jal, rwe.
  - jr: jr.
  - bex: bex.
  - setx: setx, rwe.
  - illegal: bit 15 only.
- Destination (dx_rd):
  - jal -> JAL_REG; setx -> STATUS_REG.
  - Any other instruction with rwe -> fd_rd.
  - Instructions without rwe -> 0.
- Load-use hazard:
  - Condition: dx_valid & dx_ctrl[4] & dx_rd != 0 & fd_valid & (dx_rd == fd_rs | dx_rd == fd_rt).
  - The comparison is conservative: both sources are always checked.
- Mult/div hazard: md_busy & fd_valid.
- stall = (load-use | mult/div hazard) & ~branch_taken.
- D/X register update at the rising edge, highest priority first:
  1. reset low (asynchronous): dx_ctrl = 0, dx_valid = 0, dx_rd = 0, md counter = 0, md_busy = 0.
  2. branch_taken: bubble; dx_valid = 0, dx_ctrl = 0, dx_rd = 0. The F/D instruction is discarded and never issued.
  3. stall: bubble, as in 2; the F/D instruction is retried next cycle.
  4. otherwise: dx_valid = fd_valid, with decoded dx_ctrl and dx_rd. An fd_valid = 0 cycle loads all zeros.
- Latency: decode-to-D/X is one cycle. Stall is zero-latency, combinational from the current D/X state and the inputs.
- Mult/div counter:
  - Loaded with MD_CYCLES-1 when a mult or div issues (case 4).
  - Decrements by 1 each cycle while nonzero; saturates at 0.
  - md_busy = (counter != 0), registered from the next-state value. It is high the cycle after issue for exactly MD_CYCLES-1 cycles.
  - A taken branch does not cancel an in-flight mult/div; it is older than the redirect.
- Simultaneous events:
  - branch_taken with a load-use hazard: bubble, stall = 0.
  - mult/div in F/D while md_busy: stalls until md_busy falls, then issues.
- Illegal opcode:
  - Issues with dx_valid = 1 and dx_ctrl = 0x8000.
  - rwe = 0, so it never causes a load-use hazard.
- Reset mid-operation: all state clears immediately and asynchronously. The first edge after reset release performs a normal case-4 update.

Test Plan:
- Reset low for 2 cycles with random inputs, release, then fd_valid = 0 -> dx_valid = 0, dx_ctrl = 0x0000, md_busy = 0 throughout.
- Issue addi (00101, rd = 5), then lw (01000, rd = 7), then sw (00111), then jal (00011) -> dx_ctrl 0x4007, 0x0017, 0x000C, 0x0121; dx_rd 5, 7, 0, 31 on successive cycles.
- Issue lw rd = 7, then add with rs = 7 -> stall = 1 for one cycle with a bubble (dx_valid = 0), then add issues.
  - Repeat with rd = 0 -> no stall.
  - Repeat with branch_taken high on the hazard cycle -> stall = 0 and the add is discarded.
- Issue mult (op 00000, aluop 00110) with MD_CYCLES = 4 -> md_busy high for exactly 3 cycles; the following add stalls 3 cycles, then issues.
  - A branch_taken during busy leaves md_busy unchanged.
- Issue opcode 11111 -> dx_valid = 1, dx_ctrl = 0x8000, dx_rd = 0.
  - A following instruction reading register 0 or any source register does not stall.
- Assert reset mid-stall, two cycles after a mult issues -> outputs and md_busy are 0 before the next edge; after release, the pending F/D instruction issues without a stall.
